// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_pkg
// Description : Shared types for the data-memory port arbiter: response owner,
//               return-pipeline tag and memory command payload.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_port_arbiter_pkg;

  // Widest address/data the command struct can carry; narrower ports are
  // zero-extended into it and sliced back out at the memory side.
  localparam int c_MAX_ADDR_WIDTH = 64;
  localparam int c_MAX_DATA_WIDTH = 64;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_AUX = 1'b1
  } mem_owner_e;

  typedef struct packed {
    logic       valid;
    mem_owner_e owner;
  } mem_rsp_tag_t;

  typedef struct packed {
    logic                            we;
    logic [c_MAX_ADDR_WIDTH-1:0]     addr;
    logic [c_MAX_DATA_WIDTH-1:0]     wdata;
    logic [c_MAX_DATA_WIDTH/8-1:0]   wstrb;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Bundle of the LSU, auxiliary and memory-side signals of the
//               data-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  lsu_req_i;
  logic                  lsu_we_i;
  logic [ADDR_WIDTH-1:0] lsu_addr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  logic [STRB_WIDTH-1:0] lsu_wstrb_i;
  logic                  lsu_gnt_o;
  logic                  lsu_rvalid_o;
  logic [DATA_WIDTH-1:0] lsu_rdata_o;

  logic                  aux_req_i;
  logic                  aux_we_i;
  logic [ADDR_WIDTH-1:0] aux_addr_i;
  logic [DATA_WIDTH-1:0] aux_wdata_i;
  logic [STRB_WIDTH-1:0] aux_wstrb_i;
  logic                  aux_gnt_o;
  logic                  aux_rvalid_o;
  logic [DATA_WIDTH-1:0] aux_rdata_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [STRB_WIDTH-1:0] mem_wstrb_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  stall_o;

  // Requesters and memory model side
  modport master (
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i, aux_wstrb_i,
    input  aux_gnt_o, aux_rvalid_o, aux_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_rdata_i,
    input  stall_o
  );

  // Arbiter side
  modport slave (
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i, aux_wstrb_i,
    output aux_gnt_o, aux_rvalid_o, aux_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_rdata_i,
    output stall_o
  );

endinterface
`default_nettype wire

// File: rtl/dmem_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rsp_pipe
// Description : Fixed-depth shift register of read-return tags; the last
//               stage lines up with the memory read data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rsp_pipe
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  mem_rsp_tag_t tag_i,
  output mem_rsp_tag_t tag_o
);

  mem_rsp_tag_t r_stage [DEPTH];

  // Shift tags one stage per cycle; reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign tag_o = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the data-memory port between the LSU and an auxiliary
//               requester. LSU has priority; a starvation counter forces an
//               aux grant after STARVE_LIMIT consecutive blocking LSU grants.
//               Read data is routed back to its owner after RD_LATENCY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dmem_port_arbiter_if.slave  dmem
);

  localparam int         c_STRB_WIDTH   = DATA_WIDTH / 8;
  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]   r_starve_cnt;
  logic         w_aux_force;
  logic         w_lsu_gnt;
  logic         w_aux_gnt;
  mem_req_t     w_lsu_req;
  mem_req_t     w_aux_req;
  mem_req_t     w_cmd;
  mem_rsp_tag_t w_tag_in;
  mem_rsp_tag_t w_tag_out;

  // Arbitration: LSU first unless aux has been starved long enough
  always_comb begin
    w_aux_force = dmem.aux_req_i && (r_starve_cnt == c_STARVE_LIMIT);
    w_lsu_gnt   = rst_ni && dmem.lsu_req_i && !w_aux_force;
    w_aux_gnt   = rst_ni && dmem.aux_req_i && (!dmem.lsu_req_i || w_aux_force);
  end

  // Count LSU grants that block a waiting aux; clear once aux is served or gone
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_starve_cnt <= 4'd0;
    end else if (!dmem.aux_req_i || w_aux_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_lsu_gnt && (r_starve_cnt != c_STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Command mux: winner's payload, all zero when nobody is granted
  always_comb begin
    w_lsu_req.we    = dmem.lsu_we_i;
    w_lsu_req.addr  = c_MAX_ADDR_WIDTH'(dmem.lsu_addr_i);
    w_lsu_req.wdata = c_MAX_DATA_WIDTH'(dmem.lsu_wdata_i);
    w_lsu_req.wstrb = (c_MAX_DATA_WIDTH/8)'(dmem.lsu_wstrb_i);
    w_aux_req.we    = dmem.aux_we_i;
    w_aux_req.addr  = c_MAX_ADDR_WIDTH'(dmem.aux_addr_i);
    w_aux_req.wdata = c_MAX_DATA_WIDTH'(dmem.aux_wdata_i);
    w_aux_req.wstrb = (c_MAX_DATA_WIDTH/8)'(dmem.aux_wstrb_i);
    w_cmd = '0;
    if (w_lsu_gnt) begin
      w_cmd = w_lsu_req;
    end else if (w_aux_gnt) begin
      w_cmd = w_aux_req;
    end
  end

  assign dmem.lsu_gnt_o   = w_lsu_gnt;
  assign dmem.aux_gnt_o   = w_aux_gnt;
  assign dmem.stall_o     = rst_ni && dmem.lsu_req_i && !w_lsu_gnt;
  assign dmem.mem_en_o    = w_lsu_gnt | w_aux_gnt;
  assign dmem.mem_we_o    = w_cmd.we;
  assign dmem.mem_addr_o  = w_cmd.addr[ADDR_WIDTH-1:0];
  assign dmem.mem_wdata_o = w_cmd.wdata[DATA_WIDTH-1:0];
  assign dmem.mem_wstrb_o = w_cmd.wstrb[c_STRB_WIDTH-1:0];

  // Only granted reads enter the return pipeline, tagged with their owner
  always_comb begin
    w_tag_in.valid = (w_lsu_gnt | w_aux_gnt) && !w_cmd.we;
    w_tag_in.owner = w_aux_gnt ? OWN_AUX : OWN_LSU;
  end

  dmem_rsp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (w_tag_in),
    .tag_o  (w_tag_out)
  );

  // Response demux; rvalid is masked while reset is held so nothing leaks out
  always_comb begin
    dmem.lsu_rvalid_o = rst_ni && w_tag_out.valid && (w_tag_out.owner == OWN_LSU);
    dmem.aux_rvalid_o = rst_ni && w_tag_out.valid && (w_tag_out.owner == OWN_AUX);
    dmem.lsu_rdata_o  = dmem.lsu_rvalid_o ? dmem.mem_rdata_i : '0;
    dmem.aux_rdata_o  = dmem.aux_rvalid_o ? dmem.mem_rdata_i : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter: directed scenarios
//               plus randomized traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  typedef struct {
    bit          req;    // 0 = idle slot
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          dur;    // idle: cycles; request: give up after dur cycles (0 = hold)
  } item_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dmem ();

  dmem_port_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .RD_LATENCY   (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .dmem   (dmem)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  item_t lsu_q[$];
  item_t aux_q[$];
  item_t lsu_cur, aux_cur;
  bit    lsu_act = 0, aux_act = 0;
  int    lsu_age = 0, aux_age = 0;

  // Reference model state
  int          m_starve = 0;
  logic [63:0] m_mem   [logic [63:0]];
  int          ret_own [int];            // 0 = LSU, 1 = AUX
  logic [63:0] ret_data[int];
  // Memory environment serving the DUT
  logic [63:0] env_mem [logic [63:0]];
  logic [63:0] env_rd  [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {32'hC0DE_0000 ^ a[31:0], ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] strb);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    return m_mem.exists(a) ? m_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] env_read(input logic [63:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic item_t rd(input logic [63:0] a, input int dur = 0);
    item_t it = '{req: 1, we: 0, addr: a, wdata: 64'h0, wstrb: 8'h0, dur: dur};
    return it;
  endfunction

  function automatic item_t wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    item_t it = '{req: 1, we: 1, addr: a, wdata: d, wstrb: s, dur: 0};
    return it;
  endfunction

  function automatic item_t idle(input int dur);
    item_t it = '{req: 0, we: 1, addr: {$urandom, $urandom}, wdata: {$urandom, $urandom},
                  wstrb: 8'($urandom), dur: dur};
    return it;
  endfunction

  function automatic item_t rand_item(input int busy_pct);
    logic [63:0] a = 64'h100 + 64'(8 * $urandom_range(0, 15));
    if ($urandom_range(0, 99) >= busy_pct) return idle($urandom_range(1, 3));
    if ($urandom_range(0, 2) == 0) return wr(a, {$urandom, $urandom}, 8'($urandom));
    return rd(a);
  endfunction

  // Pull the next queued item for any idle requester and drive the interface
  task automatic drive_inputs();
    if (!lsu_act && lsu_q.size() > 0) begin
      lsu_cur = lsu_q.pop_front(); lsu_act = 1; lsu_age = 0;
    end
    if (!aux_act && aux_q.size() > 0) begin
      aux_cur = aux_q.pop_front(); aux_act = 1; aux_age = 0;
    end
    dmem.lsu_req_i   = lsu_act && lsu_cur.req;
    dmem.lsu_we_i    = lsu_act ? lsu_cur.we    : 1'b0;
    dmem.lsu_addr_i  = lsu_act ? lsu_cur.addr  : 64'h0;
    dmem.lsu_wdata_i = lsu_act ? lsu_cur.wdata : 64'h0;
    dmem.lsu_wstrb_i = lsu_act ? lsu_cur.wstrb : 8'h0;
    dmem.aux_req_i   = aux_act && aux_cur.req;
    dmem.aux_we_i    = aux_act ? aux_cur.we    : 1'b0;
    dmem.aux_addr_i  = aux_act ? aux_cur.addr  : 64'h0;
    dmem.aux_wdata_i = aux_act ? aux_cur.wdata : 64'h0;
    dmem.aux_wstrb_i = aux_act ? aux_cur.wstrb : 8'h0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance model and stimulus
  task automatic run_cycle();
    bit lreq, areq, force_aux, e_lsu, e_aux, e_any, e_lv, e_av;
    item_t win;
    logic [63:0] e_ld, e_ad;
    bit d_en, d_we;
    logic [63:0] d_addr, d_wdata;
    logic [7:0]  d_strb;

    @(negedge clk_i);
    lreq      = lsu_act && lsu_cur.req;
    areq      = aux_act && aux_cur.req;
    force_aux = areq && (m_starve == LIMIT);
    e_lsu     = rst_ni && lreq && !force_aux;
    e_aux     = rst_ni && areq && (!lreq || force_aux);
    e_any     = e_lsu || e_aux;
    win       = e_lsu ? lsu_cur : aux_cur;

    check("lsu_gnt", 64'(dmem.lsu_gnt_o), 64'(e_lsu));
    check("aux_gnt", 64'(dmem.aux_gnt_o), 64'(e_aux));
    check("stall",   64'(dmem.stall_o),   64'(rst_ni && lreq && !e_lsu));
    check("mem_en",  64'(dmem.mem_en_o),  64'(e_any));
    check("mem_we",  64'(dmem.mem_we_o),  64'(e_any && win.we));
    check("mem_addr",  dmem.mem_addr_o,  e_any ? win.addr  : 64'h0);
    check("mem_wdata", dmem.mem_wdata_o, e_any ? win.wdata : 64'h0);
    check("mem_wstrb", 64'(dmem.mem_wstrb_o), 64'(e_any ? win.wstrb : 8'h0));

    e_lv = rst_ni && ret_own.exists(cyc) && (ret_own[cyc] == 0);
    e_av = rst_ni && ret_own.exists(cyc) && (ret_own[cyc] == 1);
    e_ld = e_lv ? ret_data[cyc] : 64'h0;
    e_ad = e_av ? ret_data[cyc] : 64'h0;
    check("lsu_rvalid", 64'(dmem.lsu_rvalid_o), 64'(e_lv));
    check("lsu_rdata",  dmem.lsu_rdata_o, e_ld);
    check("aux_rvalid", 64'(dmem.aux_rvalid_o), 64'(e_av));
    check("aux_rdata",  dmem.aux_rdata_o, e_ad);

    d_en = dmem.mem_en_o;     d_we = dmem.mem_we_o;
    d_addr = dmem.mem_addr_o; d_wdata = dmem.mem_wdata_o; d_strb = dmem.mem_wstrb_o;

    @(posedge clk_i);
    // Reference model at the edge
    if (!rst_ni) begin
      m_starve = 0;
      ret_own.delete();
      ret_data.delete();
    end else begin
      if (!areq || e_aux)                   m_starve = 0;
      else if (e_lsu && m_starve < LIMIT)   m_starve++;
      if (e_any) begin
        if (win.we) m_mem[win.addr] = merge(m_read(win.addr), win.wdata, win.wstrb);
        else begin
          ret_own[cyc + LAT]  = e_aux ? 1 : 0;
          ret_data[cyc + LAT] = m_read(win.addr);
        end
      end
    end
    if (ret_own.exists(cyc)) begin
      ret_own.delete(cyc);
      ret_data.delete(cyc);
    end
    // Memory environment acts on what the DUT actually issued
    if (d_en) begin
      if (d_we) env_mem[d_addr] = merge(env_read(d_addr), d_wdata, d_strb);
      else      env_rd[cyc + LAT] = env_read(d_addr);
    end
    if (env_rd.exists(cyc)) env_rd.delete(cyc);
    cyc++;

    #1;
    dmem.mem_rdata_i = env_rd.exists(cyc) ? env_rd[cyc] : {$urandom, $urandom};
    // Retire granted / expired items
    if (lsu_act) begin
      if (lsu_cur.req && e_lsu) lsu_act = 0;
      else if (!lsu_cur.req || lsu_cur.dur != 0) begin
        lsu_age++;
        if (lsu_age >= lsu_cur.dur) lsu_act = 0;
      end
    end
    if (aux_act) begin
      if (aux_cur.req && e_aux) aux_act = 0;
      else if (!aux_cur.req || aux_cur.dur != 0) begin
        aux_age++;
        if (aux_age >= aux_cur.dur) aux_act = 0;
      end
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n = 0;
    drive_inputs();
    while (((lsu_act && lsu_cur.req) || (aux_act && aux_cur.req) ||
            lsu_q.size() > 0 || aux_q.size() > 0) && n < max) begin
      run_cycle();
      n++;
    end
    check({tag, "_drained"}, 64'(n < max), 64'd1);
    repeat (LAT + 1) run_cycle();
  endtask

  initial begin
    dmem.mem_rdata_i = 64'h0;
    drive_inputs();

    // Reset state
    rst_ni = 1'b0;
    lsu_q.push_back(rd(64'h100));
    aux_q.push_back(rd(64'h108));
    drive_inputs();
    repeat (2) run_cycle();
    rst_ni = 1'b1;
    run_until_idle("post_reset", 20);

    // LSU-only back-to-back reads
    lsu_q.push_back(rd(64'h100));
    lsu_q.push_back(rd(64'h108));
    lsu_q.push_back(rd(64'h110));
    run_until_idle("lsu_only", 20);

    // Both requesting continuously: starvation limit forces aux
    for (int i = 0; i < 12; i++) lsu_q.push_back(rd(64'h100 + 64'(8 * i)));
    for (int i = 0; i < 3; i++)  aux_q.push_back(rd(64'h180 + 64'(8 * i)));
    run_until_idle("starve", 40);

    // Interleaved owners: LSU at t, aux at t+1
    lsu_q.push_back(rd(64'h118));
    aux_q.push_back(idle(1));
    aux_q.push_back(rd(64'h120));
    run_until_idle("interleave", 20);

    // Aux partial write then LSU read-back
    aux_q.push_back(wr(64'h200, 64'hFFFF_FFFF_DEAD_BEEF, 8'h0F));
    lsu_q.push_back(idle(1));
    lsu_q.push_back(rd(64'h200));
    run_until_idle("write_read", 20);

    // Reset one cycle after two reads are granted
    lsu_q.push_back(rd(64'h100));
    lsu_q.push_back(rd(64'h108));
    drive_inputs();
    repeat (2) run_cycle();
    rst_ni = 1'b0;
    run_cycle();
    rst_ni = 1'b1;
    lsu_q.push_back(rd(64'h110));
    aux_q.push_back(rd(64'h118));
    run_until_idle("reset_mid", 20);

    // Aux gives up at starve count 3, then re-requests
    for (int i = 0; i < 12; i++) lsu_q.push_back(rd(64'h140 + 64'(8 * i)));
    aux_q.push_back(rd(64'h1F0, 3));
    aux_q.push_back(idle(1));
    aux_q.push_back(rd(64'h1F8));
    run_until_idle("aux_drop", 40);

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      if (lsu_q.size() == 0) lsu_q.push_back(rand_item(75));
      if (aux_q.size() == 0) aux_q.push_back(rand_item(50));
      drive_inputs();
      if ($urandom_range(0, 99) == 0) rst_ni = 1'b0;
      run_cycle();
      rst_ni = 1'b1;
    end
    run_until_idle("random", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single synchronous data-memory port between the load/store path (MEM1 stage) and an auxiliary requester (program loader / debug access). Grants one request per cycle, tracks in-flight reads through a fixed-latency return pipeline, and routes returned read data to its owner: the LSU owner lines up with the MEM2/MEM3 registers, and the auxiliary owner gets its own return. Raises `stall_o` toward the pipeline whenever the LSU request is not granted. LSU has priority, with a starvation limit that guarantees auxiliary forward progress.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, data width; strobe width is DATA_WIDTH/8
- RD_LATENCY, 2, cycles from granted read to `mem_rdata_i` valid; range 1..4
- STARVE_LIMIT, 4, consecutive aux-blocking LSU grants before aux is forced; range 1..15

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- lsu_req_i / aux_req_i  in  1  request; held stable with its payload until granted
- lsu_we_i / aux_we_i  in  1  1 = write, 0 = read
- lsu_addr_i / aux_addr_i  in  ADDR_WIDTH  byte address
- lsu_wdata_i / aux_wdata_i  in  DATA_WIDTH  write data
- lsu_wstrb_i / aux_wstrb_i  in  DATA_WIDTH/8  byte enables
- lsu_gnt_o / aux_gnt_o  out  1  request accepted this cycle
- lsu_rvalid_o / aux_rvalid_o  out  1  read data returned this cycle
- lsu_rdata_o / aux_rdata_o  out  DATA_WIDTH  read data; 0 when the matching rvalid is low
- mem_en_o, mem_we_o  out  1  memory command strobe and write flag
- mem_addr_o, mem_wdata_o, mem_wstrb_o  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  command payload
- mem_rdata_i  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after the read command
- stall_o  out  1  `lsu_req_i && !lsu_gnt_o`

## Operation
- Grant is combinational, in the same cycle as the request. At most one grant per cycle.
- Default: LSU wins if `lsu_req_i`. Aux wins if it is the sole requester.
- Aux also wins if `aux_req_i` is high and `starve_cnt == STARVE_LIMIT`.
- `starve_cnt` (4 bits) update:
  - +1, saturating at STARVE_LIMIT, when LSU is granted while `aux_req_i` is high.
  - Cleared to 0 when aux is granted, or when `aux_req_i` is low.
- Memory command mirrors the winner's payload. `mem_en_o = lsu_gnt_o | aux_gnt_o`. With no grant, all payload outputs are 0.
- Return pipeline: RD_LATENCY stages of {valid, owner}.
  - Stage 0 loads valid = `granted && !we`, owner = winner.
  - At the last stage, the valid bit drives the owner's rvalid, and `mem_rdata_i` is routed to the owner's rdata.
- Writes produce no rvalid. Read-after-write to the same address is ordered by grant order only; there is no forwarding.
- The pipeline fills back-to-back: one read per cycle sustained, with no bubble between owners.

## Timing
- Reset (`rst_ni` = 0 at an edge):
  - `starve_cnt` = 0 and the return pipeline is cleared.
  - While `rst_ni` is low, all grants, `mem_en_o` and `stall_o` are forced to 0.
- Reset mid-operation: reads in flight are dropped, and no rvalid is asserted for them after reset.
- Read latency: a grant at cycle t gives rvalid at cycle t+RD_LATENCY.
- Write: committed by memory at the grant edge.
- Simultaneous requests: exactly one grant. `stall_o` = 1 in any cycle the LSU loses.
- Saturation: `starve_cnt` never exceeds STARVE_LIMIT. The forced aux grant resets it the same edge.

## Structure
- `pipeline_pkg` gains:
  - `mem_owner_e` {OWN_LSU, OWN_AUX}
  - `mem_rsp_tag_t` {valid, owner}
  - `mem_req_t` {we, addr, wdata, wstrb}
- One sub-module, `dmem_rsp_pipe`: RD_LATENCY-deep shift register of `mem_rsp_tag_t`, with synchronous active-low clear.
- Top-level `dmem_port_arbiter` holds the grant logic, `starve_cnt`, the command mux and the response demux.

## Test plan
- LSU-only reads to 0x100, 0x108, 0x110 on consecutive cycles:
  - 3 grants, `mem_addr_o` in order.
  - `lsu_rvalid_o` at t+2..t+4 with memory contents.
  - `stall_o` stays 0.
- Both requesting continuously, STARVE_LIMIT = 4:
  - Grant sequence LSU×4, AUX, LSU×4, AUX.
  - `stall_o` = 1 exactly on the AUX cycles.
- Interleaved reads, LSU at t and aux at t+1:
  - `lsu_rvalid_o` at t+2 and `aux_rvalid_o` at t+3, each with the correct data.
  - The other owner's rdata is 0 in those cycles.
- Aux write 0xDEADBEEF strb 0x0F to 0x200, then LSU read of 0x200:
  - The write produces no rvalid.
  - Read data lower word = 0xDEADBEEF.
- `rst_ni` pulsed low 1 cycle after two reads are granted:
  - No rvalid is ever asserted for them; `starve_cnt` = 0.
  - First grant after reset is LSU.
- `aux_req_i` dropped while `starve_cnt` = 3:
  - Counter clears.
  - On re-request, 4 further LSU grants occur before aux is forced.
